// File: rtl/arb_pkg.sv
// arb_pkg: shared encodings and sizes for the round-robin arbiter
package arb_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
endpackage

// File: rtl/arb_onehot_dec.sv
// arb_onehot_dec: 2-to-4 one-hot decoder with enable
module arb_onehot_dec
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] in,
  input  logic             en,
  output logic [N_REQ-1:0] out
);
  always_comb out = en ? {{(N_REQ-1){1'b0}}, 1'b1} << in : '0;
endmodule

// File: rtl/rr_arb4_ctrl.sv
// rr_arb4_ctrl: 4-way round-robin arbiter with hold timeout and registered grant outputs
module rr_arb4_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             hold_tmo
);
  state_t            state;
  logic [IDX_W-1:0]  ptr, off, hit, idx_nx;
  logic [N_REQ-1:0]  rot, gnt_nx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              own_req, tmo, rel, vld_nx;
  // rotate req so the pointer position lands at bit 0, then take the first hit
  always_comb begin
    rot = ptr == 2'd0 ? req :
          ptr == 2'd1 ? {req[0], req[3:1]} :
          ptr == 2'd2 ? {req[1:0], req[3:2]} : {req[2:0], req[3]};
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    hit = ptr + off;
    own_req = req[gnt_idx];
    tmo = own_req && hold_cnt == HOLD_W'(MAX_HOLD - 1);
    rel = state == S_BUSY && (!own_req || tmo);
    idx_nx = state == S_IDLE && |req ? hit : gnt_idx;
    vld_nx = state == S_IDLE ? |req : !rel;
  end
  arb_onehot_dec u_dec (.in(idx_nx), .en(vld_nx), .out(gnt_nx));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      hold_tmo <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state == S_IDLE ? (|req ? S_BUSY : S_IDLE) : (rel ? S_IDLE : S_BUSY);
      gnt      <= gnt_nx;
      gnt_idx  <= idx_nx;
      gnt_vld  <= vld_nx;
      hold_tmo <= rel && tmo;
      ptr      <= rel ? gnt_idx + 1'b1 : ptr;
      hold_cnt <= state == S_IDLE ? '0 : &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// tb_rr_arb4_ctrl: directed scenario tests for rr_arb4_ctrl
module tb_rr_arb4_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld, hold_tmo;
  logic [7:0] obs, exp_obs, exp_gnt;
  int         checks = 0, errors = 0;
  rr_arb4_ctrl #(.MAX_HOLD(16), .HOLD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .hold_tmo(hold_tmo)
  );
  always #5 clk = ~clk;
  assign obs = {gnt_vld, gnt_idx, gnt, hold_tmo};
  // grant vector must always be the gated decode of the index
  always @(negedge clk) begin
    exp_gnt = gnt_vld ? 8'(4'b0001 << gnt_idx) : 8'h00;
    checks++;
    if (gnt !== exp_gnt[3:0] || !$onehot0(gnt)) begin
      errors++;
      $display("FAIL gnt_decode: gnt=%b idx=%0d vld=%b want gnt=%b", gnt, gnt_idx, gnt_vld, exp_gnt[3:0]);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_obs(input string name, input logic [7:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got vld/idx/gnt/tmo=%b_%0d_%b_%b want %b_%0d_%b_%b", name,
               obs[7], obs[6:5], obs[4:1], obs[0], want[7], want[6:5], want[4:1], want[0]);
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    req = 4'b0000;
    tick;
    tick;
    expect_obs("reset_state", {1'b0, 2'd0, 4'b0000, 1'b0});
    rst_n = 1'b1;
    tick;
    expect_obs("idle_after_reset", {1'b0, 2'd0, 4'b0000, 1'b0});
  endtask
  task automatic test_single;
    req = 4'b0001;
    tick;
    expect_obs("single_grant", {1'b1, 2'd0, 4'b0001, 1'b0});
    req = 4'b0000;
    tick;
    expect_obs("single_release", {1'b0, 2'd0, 4'b0000, 1'b0});
    req = 4'b0011;
    tick;
    expect_obs("ptr_advanced", {1'b1, 2'd1, 4'b0010, 1'b0});
    req = 4'b0000;
    tick;
    expect_obs("ptr_release", {1'b0, 2'd1, 4'b0000, 1'b0});
  endtask
  task automatic test_rotation;
    logic [1:0] e;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = 2'(k);
      tick;
      expect_obs("rotate_grant", {1'b1, e, 4'(4'b0001 << e), 1'b0});
      tick;
      tick;
      expect_obs("rotate_hold", {1'b1, e, 4'(4'b0001 << e), 1'b0});
      req[e] = 1'b0;
      tick;
      expect_obs("rotate_gap", {1'b0, e, 4'b0000, 1'b0});
      req = 4'b1111;
    end
    req = 4'b0000;
    tick;
  endtask
  task automatic test_timeout;
    req = 4'b0100;
    tick;
    repeat (16) begin
      expect_obs("timeout_hold", {1'b1, 2'd2, 4'b0100, 1'b0});
      tick;
    end
    expect_obs("timeout_release", {1'b0, 2'd2, 4'b0000, 1'b1});
    tick;
    expect_obs("timeout_regrant", {1'b1, 2'd2, 4'b0100, 1'b0});
    req = 4'b0000;
    tick;
    expect_obs("timeout_drop", {1'b0, 2'd2, 4'b0000, 1'b0});
  endtask
  task automatic test_timeout_rotate;
    req = 4'b0110;
    tick;
    expect_obs("tmo_rot_grant", {1'b1, 2'd1, 4'b0010, 1'b0});
    repeat (15) tick;
    expect_obs("tmo_rot_last", {1'b1, 2'd1, 4'b0010, 1'b0});
    tick;
    expect_obs("tmo_rot_release", {1'b0, 2'd1, 4'b0000, 1'b1});
    tick;
    expect_obs("tmo_rot_next", {1'b1, 2'd2, 4'b0100, 1'b0});
    req = 4'b0000;
    tick;
    expect_obs("tmo_rot_drop", {1'b0, 2'd2, 4'b0000, 1'b0});
  endtask
  task automatic test_drop_at_limit;
    req = 4'b1000;
    tick;
    expect_obs("limit_grant", {1'b1, 2'd3, 4'b1000, 1'b0});
    repeat (15) tick;
    expect_obs("limit_last", {1'b1, 2'd3, 4'b1000, 1'b0});
    req = 4'b0000;
    tick;
    expect_obs("limit_release", {1'b0, 2'd3, 4'b0000, 1'b0});
    tick;
    expect_obs("limit_idle", {1'b0, 2'd3, 4'b0000, 1'b0});
  endtask
  task automatic test_async_reset;
    req = 4'b0010;
    tick;
    expect_obs("async_pre", {1'b1, 2'd1, 4'b0010, 1'b0});
    #2 rst_n = 1'b0;
    #1 expect_obs("async_immediate", {1'b0, 2'd0, 4'b0000, 1'b0});
    req = 4'b1000;
    tick;
    expect_obs("async_held", {1'b0, 2'd0, 4'b0000, 1'b0});
    rst_n = 1'b1;
    tick;
    expect_obs("async_regrant", {1'b1, 2'd3, 4'b1000, 1'b0});
    req = 4'b0000;
    tick;
    expect_obs("async_drop", {1'b0, 2'd3, 4'b0000, 1'b0});
  endtask
  initial begin
    test_reset;
    test_single;
    test_rotation;
    test_timeout;
    test_timeout_rotate;
    test_drop_at_limit;
    test_async_reset;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
